// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the 5-stage pipeline hazard scoreboard.
//   REG_W          : GPR number width
//   MDU_CNT_W      : width of the HI/LO pending counter (latency 1..15)
//   slot_t         : one in-flight writer entry {valid, rd, regwrite, is_load}
//   stall_reason_e : why decode is held, kept for debug visibility
//   slot_writes()  : effective GPR write of a slot (register 0 never tracked)
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int REG_W     = 5;
  localparam int MDU_CNT_W = 4;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             is_load;
  } slot_t;

  typedef enum logic [1:0] {
    STALL_NONE     = 2'd0,
    STALL_LOAD_USE = 2'd1,
    STALL_MDU      = 2'd2
  } stall_reason_e;

  function automatic logic slot_writes(input slot_t s);
    return s.valid && s.regwrite && (s.rd != {REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/mdu_busy_counter.sv
// -----------------------------------------------------------------------------
// mdu_busy_counter
// Down-counter tracking how long the multi-cycle multiply/divide unit still
// needs before HI/LO is valid. Loading restarts the count at LATENCY; the
// count then decrements once per cycle until it reaches zero.
// Ports:
//   clk  in  pipeline clock
//   rst  in  synchronous active-high reset (clears the count)
//   load in  MDU instruction actually issued this cycle
//   busy out HI/LO result pending (count != 0), derived from a register only
// -----------------------------------------------------------------------------
module mdu_busy_counter
  import pipe_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  logic [MDU_CNT_W-1:0] cnt;

  // Count register: load has priority over decrement, idle at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {MDU_CNT_W{1'b0}};
    end else if (load) begin
      cnt <= MDU_CNT_W'(LATENCY);
    end else if (cnt != {MDU_CNT_W{1'b0}}) begin
      cnt <= cnt - {{(MDU_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign busy = (cnt != {MDU_CNT_W{1'b0}});

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks in-flight GPR writers through EX, MEM and WB, publishes the EX/MEM and
// MEM/WB destination tags used by forwarding, and raises a decode stall for
// load-use hazards and (optionally) HI/LO access while the MDU is busy.
//
// Build option: define HAZARD_SCOREBOARD_MDU_EN to include the MDU busy
// counter, mdu_busy and the MDU stall. Without it mdu_busy is 0 and
// id_is_mdu / id_reads_hilo are ignored.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_valid                    ID holds a real instruction
//   id_rs, id_rt, id_uses_rs/rt source registers and whether they are read
//   id_rd, id_regwrite          destination and GPR write enable
//   id_is_load                  load (result only after MEM)
//   id_is_mdu, id_reads_hilo    mult/div issue, mfhi/mflo
//   flush                       kill the instruction in ID
//   stall                       hold PC and IF/ID, bubble into ID/EX (comb)
//   exmem_rd/_regwrite          MEM-slot writer (registered)
//   memwb_rd/_regwrite          WB-slot writer (registered)
//   mdu_busy                    HI/LO result pending (registered)
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int MDU_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_is_load,
  input  logic       id_is_mdu,
  input  logic       id_reads_hilo,
  input  logic       flush,
  output logic       stall,
  output logic [4:0] exmem_rd,
  output logic       exmem_regwrite,
  output logic [4:0] memwb_rd,
  output logic       memwb_regwrite,
  output logic       mdu_busy
);

  slot_t         ex_slot;
  slot_t         mem_slot;
  slot_t         wb_slot;
  slot_t         new_slot;
  slot_t         ex_clean;
  logic          issue;
  logic          load_use;
  logic          mdu_stall;
  stall_reason_e stall_reason;

  assign issue = id_valid && !stall && !flush;

  // Build the entry entering EX; a bubble when nothing issues.
  always_comb begin
    new_slot = '0;
    if (issue) begin
      new_slot.valid    = 1'b1;
      new_slot.rd       = id_rd;
      new_slot.regwrite = id_regwrite;
      new_slot.is_load  = id_is_load;
    end else begin
      new_slot = '0;
    end
  end

  // EX entry reduced to its effective write so MEM/WB outputs read 0 when idle.
  always_comb begin
    ex_clean          = ex_slot;
    ex_clean.regwrite = slot_writes(ex_slot);
    if (slot_writes(ex_slot)) begin
      ex_clean.rd = ex_slot.rd;
    end else begin
      ex_clean.rd = {REG_W{1'b0}};
    end
  end

  // Three-slot shift pipeline EX -> MEM -> WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else begin
      ex_slot  <= new_slot;
      mem_slot <= ex_clean;
      wb_slot  <= mem_slot;
    end
  end

  assign exmem_rd       = mem_slot.rd;
  assign exmem_regwrite = mem_slot.regwrite;
  assign memwb_rd       = wb_slot.rd;
  assign memwb_regwrite = wb_slot.regwrite;

  // Load-use: the load in EX has no result until after MEM, so ID must wait.
  always_comb begin
    load_use = 1'b0;
    if (id_valid && ex_slot.valid && ex_slot.is_load &&
        (ex_slot.rd != {REG_W{1'b0}}) &&
        ((id_uses_rs && (ex_slot.rd == id_rs)) ||
         (id_uses_rt && (ex_slot.rd == id_rt)))) begin
      load_use = 1'b1;
    end else begin
      load_use = 1'b0;
    end
  end

`ifdef HAZARD_SCOREBOARD_MDU_EN
  mdu_busy_counter #(
    .LATENCY (MDU_LATENCY)
  ) u_mdu_busy_counter (
    .clk  (clk),
    .rst  (rst),
    .load (issue && id_is_mdu),
    .busy (mdu_busy)
  );

  assign mdu_stall = id_valid && mdu_busy && (id_is_mdu || id_reads_hilo);
`else
  logic unused_mdu_inputs;
  assign unused_mdu_inputs = id_is_mdu ^ id_reads_hilo;
  assign mdu_busy          = 1'b0;
  assign mdu_stall         = 1'b0;
`endif

  // Stall cause; reset and flush override any hazard.
  always_comb begin
    stall_reason = STALL_NONE;
    if (rst || flush) begin
      stall_reason = STALL_NONE;
    end else if (load_use) begin
      stall_reason = STALL_LOAD_USE;
    end else if (mdu_stall) begin
      stall_reason = STALL_MDU;
    end else begin
      stall_reason = STALL_NONE;
    end
  end

  assign stall = (stall_reason != STALL_NONE);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed opening sequence followed by random decode traffic. The reference
// model keeps a per-cycle history of what actually issued and derives every
// output from issue-cycle arithmetic: an entry issued in cycle t is in EX at
// t+1, on exmem_* at t+2, on memwb_* at t+3 unless a reset intervened, and an
// MDU issue at m keeps HI/LO busy for cycles m+1..m+LAT.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int LAT  = 4;
  localparam int NCYC = 3000;

`ifdef HAZARD_SCOREBOARD_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_is_load;
  logic       id_is_mdu;
  logic       id_reads_hilo;
  logic       flush;
  logic       stall;
  logic [4:0] exmem_rd;
  logic       exmem_regwrite;
  logic [4:0] memwb_rd;
  logic       memwb_regwrite;
  logic       mdu_busy;

  hazard_scoreboard #(.MDU_LATENCY(LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_rd          (id_rd),
    .id_regwrite    (id_regwrite),
    .id_is_load     (id_is_load),
    .id_is_mdu      (id_is_mdu),
    .id_reads_hilo  (id_reads_hilo),
    .flush          (flush),
    .stall          (stall),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .mdu_busy       (mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // History of what issued in each cycle.
  bit       iss    [NCYC];
  bit [4:0] iss_rd [NCYC];
  bit       iss_rw [NCYC];
  bit       iss_ld [NCYC];
  int       last_rst;
  int       last_mdu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int rd, input bit rw, input bit ld, input bit mdu,
                        input bit hilo, input bit fl, input bit r);
    id_valid      = v;
    id_rs         = 5'(rs);
    id_rt         = 5'(rt);
    id_uses_rs    = urs;
    id_uses_rt    = urt;
    id_rd         = 5'(rd);
    id_regwrite   = rw;
    id_is_load    = ld;
    id_is_mdu     = mdu;
    id_reads_hilo = hilo;
    flush         = fl;
    rst           = r;
  endtask

  task automatic drive(input int c);
    case (c)
      0, 1: set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      2:    set_in(1'b1, 1, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // lw $3
      3, 4: set_in(1'b1, 3, 5, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // add $4,$3,$5
      5:    set_in(1'b1, 6, 7, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // mult
      6, 7, 8, 9, 10:
            set_in(1'b1, 0, 0, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // mflo $8
      11:   set_in(1'b1, 2, 0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // lw $0
      12:   set_in(1'b1, 0, 0, 1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // uses $0
      13:   set_in(1'b1, 1, 0, 1'b1, 1'b0, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // lw $7
      14:   set_in(1'b1, 7, 7, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); // flushed dep
      15:   set_in(1'b1, 1, 0, 1'b1, 1'b0, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // lw $5 + mult
      16:   set_in(1'b1, 5, 0, 1'b1, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // both hazards
      17:   set_in(1'b1, 5, 0, 1'b1, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); // reset mid-stall
      default: set_in($urandom_range(0, 9) != 0,
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 59) == 0);
    endcase
  endtask

  function automatic bit alive(input int t, input int c);
    return (t >= 0) && (t < c) && iss[t] && (t > last_rst);
  endfunction

  initial begin
    bit       lu;
    bit       busy_e;
    bit       md;
    bit       stall_e;
    bit       ok;
    bit [4:0] rd_e;
    last_rst = -1000;
    last_mdu = -1000;
    for (int i = 0; i < NCYC; i++) begin
      iss[i]    = 1'b0;
      iss_rd[i] = 5'd0;
      iss_rw[i] = 1'b0;
      iss_ld[i] = 1'b0;
    end
    set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      drive(c);
      @(negedge clk);

      // Expected behaviour for this cycle from the issue history.
      lu = alive(c - 1, c) && iss_ld[c-1] && (iss_rd[c-1] != 5'd0) && id_valid &&
           ((id_uses_rs && iss_rd[c-1] == id_rs) || (id_uses_rt && iss_rd[c-1] == id_rt));
      busy_e  = MDU_EN && (last_mdu > last_rst) && (c - last_mdu >= 1) && (c - last_mdu <= LAT);
      md      = id_valid && busy_e && (id_is_mdu || id_reads_hilo);
      stall_e = !(rst || flush) && (lu || md);

      if (c >= 1) begin
        check("stall", {31'd0, stall}, {31'd0, stall_e});
        check("mdu_busy", {31'd0, mdu_busy}, {31'd0, busy_e});
        ok   = alive(c - 2, c) && iss_rw[c-2] && (iss_rd[c-2] != 5'd0);
        rd_e = ok ? iss_rd[c-2] : 5'd0;
        check("exmem_regwrite", {31'd0, exmem_regwrite}, {31'd0, ok});
        check("exmem_rd", {27'd0, exmem_rd}, {27'd0, rd_e});
        ok   = alive(c - 3, c) && iss_rw[c-3] && (iss_rd[c-3] != 5'd0);
        rd_e = ok ? iss_rd[c-3] : 5'd0;
        check("memwb_regwrite", {31'd0, memwb_regwrite}, {31'd0, ok});
        check("memwb_rd", {27'd0, memwb_rd}, {27'd0, rd_e});
      end

      // Record what the pipeline accepts at the end of this cycle.
      iss[c]    = !rst && id_valid && !stall_e && !flush;
      iss_rd[c] = id_rd;
      iss_rw[c] = id_regwrite;
      iss_ld[c] = id_is_load;
      if (iss[c] && id_is_mdu) last_mdu = c;
      if (rst) last_rst = c;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer-side companion to the EX-stage forwarding logic in the 5-stage pipeline. Tracks every in-flight register writer from issue through EX, MEM and WB, and publishes the EX/MEM and MEM/WB destination tags the forwarding logic consumes. Raises a decode-stage stall for hazards that forwarding cannot cover: load-use, and HI/LO access while the multi-cycle multiply/divide unit is busy. Sits beside the ID stage and drives the PC/IF-ID hold and the ID/EX bubble.

## Interface
- MDU_LATENCY, 4: cycles from MDU issue until HI/LO is valid (range 1..15).
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  5  source register numbers.
- id_uses_rs, id_uses_rt  in  1  the source is actually read.
- id_rd  in  5  destination register.
- id_regwrite  in  1  instruction writes a GPR.
- id_is_load  in  1  instruction is a load (result available after MEM).
- id_is_mdu  in  1  mult/div issue (writes HI/LO, not a GPR).
- id_reads_hilo  in  1  mfhi/mflo.
- flush  in  1  kill the instruction in ID (mispredict or exception).
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- exmem_rd  out  5  destination register of the MEM-stage entry.
- exmem_regwrite  out  1  MEM-stage entry writes a GPR.
- memwb_rd  out  5  destination register of the WB-stage entry.
- memwb_regwrite  out  1  WB-stage entry writes a GPR.
- mdu_busy  out  1  HI/LO result pending.

## Operation
- Internal three-slot shift pipeline (EX, MEM, WB). Each slot holds {valid, rd, regwrite, is_load}. Every cycle: WB←MEM, MEM←EX, EX←new entry.
- New entry is valid only when id_valid && !stall && !flush. Otherwise EX loads a bubble (valid=0).
- Effective regwrite of a slot = valid && regwrite && rd != 0. Register 0 is never tracked.
- exmem_* reflect the MEM slot; memwb_* reflect the WB slot. exmem_rd/memwb_rd read 0 when the effective regwrite is 0.
- Load-use stall: EX slot valid && is_load && rd != 0 && ((id_uses_rs && rd==id_rs) || (id_uses_rt && rd==id_rt)), qualified by id_valid.
- MDU tracking: 4-bit down-counter cnt. id_is_mdu issue (not stalled, not flushed) loads MDU_LATENCY. When cnt != 0 it decrements by 1 per cycle. mdu_busy = (cnt != 0).
- MDU stall: id_valid && mdu_busy && (id_is_mdu || id_reads_hilo).
- stall = load-use stall || MDU stall, forced to 0 while rst or flush is high.
- Flush does not touch the MEM/WB slots (older instructions), the EX slot, or an already-running MDU count.

## Timing
- Reset: all slots invalid, cnt=0. Every output is 0 during and after reset until the first issue.
- stall is combinational from the ID inputs and registered state, valid in the same cycle.
- Outputs exmem_*/memwb_* are registered. An instruction issued in cycle t appears on exmem_* in cycle t+2 and on memwb_* in cycle t+3.
- Load-use costs exactly 1 stall cycle. After that, the load sits in MEM and the dependent instruction forwards from MEM/WB.
- MDU issued at cycle t: mdu_busy is high for cycles t+1..t+MDU_LATENCY. A dependent mfhi/mflo in ID at t+1 stalls MDU_LATENCY cycles.
- Load-use and MDU conditions in the same cycle: a single stall; each condition clears independently.
- Reset asserted mid-stall: next cycle everything is cleared and stall=0.

## Configuration
- HAZARD_SCOREBOARD_MDU_EN defined: MDU counter, mdu_busy and MDU stall are present as described.
- Not defined: no counter, mdu_busy tied to 0, id_is_mdu/id_reads_hilo ignored. Stall is load-use only.

## Structure
- Shared package pipe_pkg:
  - slot typedef (valid, rd, regwrite, is_load)
  - REG_W=5 constant
  - stall-reason enum (NONE, LOAD_USE, MDU) for debug visibility
- One sub-module, mdu_busy_counter (load, decrement, busy), instantiated only under HAZARD_SCOREBOARD_MDU_EN. The slot pipeline stays inline.

## Test plan
- lw $3 issued, then add $4,$3,$5 in ID next cycle → stall=1 for exactly 1 cycle. Two cycles after the lw issues: exmem_rd=3, exmem_regwrite=1. One cycle later: memwb_rd=3.
- Writer with rd=0 (regwrite=1), then a dependent on $0 → never stalls; exmem_regwrite=0, exmem_rd=0.
- mult issued with MDU_LATENCY=4, mflo in ID next cycle → mdu_busy high 4 cycles, stall high 4 cycles, mflo issues in cycle 5.
- lw $7 followed by an instruction with flush=1 whose source is $7 → stall=0, and no valid entry enters EX.
- rst asserted during an MDU count and a pending load-use → next cycle: all outputs 0, mdu_busy=0, stall=0.
- Macro undefined: mult then mflo back-to-back → stall=0, mdu_busy=0. Load-use still stalls 1 cycle.
